// File: rtl/debounce_pkg.sv
// Shared types and default sizing for the debounce_edge qualifier.
package debounce_pkg;

  localparam int unsigned DEF_STABLE_CYCLES = 16;
  localparam int unsigned DEF_EVT_W         = 8;

  // Gray-style encoding: stable/check pairs differ in one bit
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    CHK_HI    = 2'b01,
    STABLE_HI = 2'b11,
    CHK_LO    = 2'b10
  } state_t;

endpackage

// File: rtl/debounce_timer.sv
// Qualification counter: counts consecutive candidate samples, saturating at
// STABLE_CYCLES-1 where done_c asserts.
module debounce_timer
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic done_c
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  assign done_c = (cnt == CNT_W'(STABLE_CYCLES - 1));

  // Clear wins over increment; never advance past the done value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !done_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/debounce_edge.sv
// Debounced level with one-cycle rise/fall pulses and an optional rising-event
// counter (built when DEBOUNCE_EVTCNT_EN is defined, otherwise evt_cnt reads 0).
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned EVT_W         = DEF_EVT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             evt_clr,
  output logic             q,
  output logic             rise,
  output logic             fall,
  output logic [EVT_W-1:0] evt_cnt
);

  state_t state, state_nxt;
  logic   tmr_clr_c, tmr_inc_c, tmr_done_c;
  logic   q_nxt, rise_nxt, fall_nxt;

  debounce_timer #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr_c),
    .inc   (tmr_inc_c),
    .done_c(tmr_done_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STABLE_LO;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // Any opposite sample while checking drops back to the stable state
  always_comb begin
    state_nxt = state;
    tmr_clr_c = 1'b0;
    tmr_inc_c = 1'b0;
    q_nxt     = q;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state)
      STABLE_LO: begin
        if (d) begin
          state_nxt = CHK_HI;
          tmr_inc_c = 1'b1;
        end else begin
          tmr_clr_c = 1'b1;
        end
      end
      CHK_HI: begin
        if (!d) begin
          state_nxt = STABLE_LO;
          tmr_clr_c = 1'b1;
        end else if (tmr_done_c) begin
          state_nxt = STABLE_HI;
          q_nxt     = 1'b1;
          rise_nxt  = 1'b1;
          tmr_clr_c = 1'b1;
        end else begin
          tmr_inc_c = 1'b1;
        end
      end
      STABLE_HI: begin
        if (!d) begin
          state_nxt = CHK_LO;
          tmr_inc_c = 1'b1;
        end else begin
          tmr_clr_c = 1'b1;
        end
      end
      CHK_LO: begin
        if (d) begin
          state_nxt = STABLE_HI;
          tmr_clr_c = 1'b1;
        end else if (tmr_done_c) begin
          state_nxt = STABLE_LO;
          q_nxt     = 1'b0;
          fall_nxt  = 1'b1;
          tmr_clr_c = 1'b1;
        end else begin
          tmr_inc_c = 1'b1;
        end
      end
      default: begin
        state_nxt = STABLE_LO;
        tmr_clr_c = 1'b1;
      end
    endcase
  end

`ifdef DEBOUNCE_EVTCNT_EN
  // Counts cycles where rise is high; a clear coinciding with rise keeps that event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_cnt <= '0;
    end else if (evt_clr) begin
      evt_cnt <= rise ? EVT_W'(1) : '0;
    end else if (rise) begin
      evt_cnt <= evt_cnt + EVT_W'(1);
    end
  end
`else
  logic unused_evt_clr;

  assign unused_evt_clr = evt_clr;
  assign evt_cnt        = '0;
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: directed table, corner sequences, then random
// stimulus against a sample-history reference model.
module tb_debounce_edge;

  localparam int unsigned STABLE_CYCLES = 4;
  localparam int unsigned EVT_W         = 4;
`ifdef DEBOUNCE_EVTCNT_EN
  localparam bit EVT_EN = 1'b1;
`else
  localparam bit EVT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             d;
  logic             evt_clr;
  logic             q;
  logic             rise;
  logic             fall;
  logic [EVT_W-1:0] evt_cnt;

  int n_vec = 0;
  int n_err = 0;

  debounce_edge #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .EVT_W        (EVT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .d      (d),
    .evt_clr(evt_clr),
    .q      (q),
    .rise   (rise),
    .fall   (fall),
    .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: keep the samples seen since the last level change; a
  // change is accepted once the newest STABLE_CYCLES samples all oppose q.
  logic             m_q, m_rise, m_fall;
  logic [EVT_W-1:0] m_evt;
  logic             hist[$];

  task automatic model_reset();
    m_q    = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_evt  = '0;
    hist.delete();
  endtask

  task automatic model_step(input logic dv, input logic cv);
    bit acc;
    if (EVT_EN) begin
      if (cv) m_evt = m_rise ? EVT_W'(1) : EVT_W'(0);
      else if (m_rise) m_evt = m_evt + EVT_W'(1);
    end
    hist.push_back(dv);
    if (hist.size() > STABLE_CYCLES) void'(hist.pop_front());
    acc = (hist.size() == STABLE_CYCLES);
    foreach (hist[i]) if (hist[i] == m_q) acc = 1'b0;
    m_rise = acc && !m_q;
    m_fall = acc && m_q;
    if (acc) begin
      m_q = ~m_q;
      hist.delete();
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [EVT_W-1:0] evt_exp(input logic [EVT_W-1:0] v);
    return EVT_EN ? v : EVT_W'(0);
  endfunction

  // One clock: drive, let the edge happen, advance the model, compare {q,rise,fall,evt}
  task automatic tick(input logic dv, input logic cv);
    d       = dv;
    evt_clr = cv;
    @(posedge clk);
    model_step(dv, cv);
    #1;
    check("model", 32'({q, rise, fall, evt_cnt}), 32'({m_q, m_rise, m_fall, m_evt}));
  endtask

  task automatic press();
    repeat (STABLE_CYCLES) tick(1'b1, 1'b0);
    repeat (STABLE_CYCLES + 1) tick(1'b0, 1'b0);
  endtask

  typedef struct {
    logic             d;
    logic             clr;
    logic             q;
    logic             rise;
    logic             fall;
    logic [EVT_W-1:0] evt;
  } vec_t;

  function automatic vec_t mk(input logic dv, input logic cv, input logic qv,
                              input logic rv, input logic fv, input logic [EVT_W-1:0] ev);
    vec_t v;
    v.d = dv; v.clr = cv; v.q = qv; v.rise = rv; v.fall = fv; v.evt = ev;
    return v;
  endfunction

  vec_t tbl[18];
  logic dcur;

  initial begin
    // d high through reset, then hold: rise on 4th edge, glitches, fall
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tbl[3]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    tbl[4]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    tbl[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    tbl[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    tbl[7]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    tbl[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);

    rst     = 1'b1;
    d       = 1'b1;
    evt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'({q, rise, fall, evt_cnt}), 32'(0));
    #3 rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].d, tbl[i].clr);
      check($sformatf("tbl[%0d]", i), 32'({q, rise, fall, evt_cnt}),
            32'({tbl[i].q, tbl[i].rise, tbl[i].fall, evt_exp(tbl[i].evt)}));
    end

    // Counter clear, then wrap through 16 presses
    tick(1'b0, 1'b1);
    check("evt_clr_alone", 32'(evt_cnt), 32'(0));
    for (int p = 1; p <= 16; p++) begin
      press();
      if (p == 15) check("evt_15", 32'(evt_cnt), 32'(evt_exp(4'd15)));
      if (p == 16) check("evt_wrap", 32'(evt_cnt), 32'(evt_exp(4'd0)));
    end

    // Clear in the same cycle rise is high keeps that event
    repeat (STABLE_CYCLES) tick(1'b1, 1'b0);
    check("rise_before_clr", 32'(rise), 32'(1));
    tick(1'b1, 1'b1);
    check("evt_clr_with_rise", 32'(evt_cnt), 32'(evt_exp(4'd1)));
    repeat (STABLE_CYCLES + 1) tick(1'b0, 1'b0);

    // Async reset mid-qualification, released with d still high
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("async_rst", 32'({q, rise, evt_cnt}), 32'(0));
    model_reset();
    #2 rst = 1'b0;
    for (int i = 0; i < STABLE_CYCLES - 1; i++) begin
      tick(1'b1, 1'b0);
      check("post_rst_q_low", 32'({q, rise}), 32'(0));
    end
    tick(1'b1, 1'b0);
    check("post_rst_rise", 32'({q, rise}), 32'(2'b11));

    // Random runs of varying length against the model
    dcur = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 4) == 0) dcur = ~dcur;
      tick(dcur, ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
